// File: rtl/puf_chal_sweep_sched.sv
// rtl/puf_chal_sweep_sched.sv - enrollment sweep scheduler over all RO pairs; optional GAP state via PUF_SCHED_GAP_EN
module puf_chal_sweep_sched #(
  parameter int MUX_LENGTH  = 16,
  parameter int REP_W       = 4,
  parameter int TMO_W       = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int GAP_CYC     = 64,
  localparam int SEL_W      = $clog2(MUX_LENGTH),
  localparam int CHAL_W     = 2 * SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sweep_start,
  input  logic             i_sweep_abort,
  input  logic             i_op_mode,
  input  logic [REP_W-1:0] i_rep_cnt,
  output logic             o_start,
  output logic             o_op_mode,
  input  logic             i_rx_ready,
  output logic             o_rx_valid,
  output logic             o_rx_data,
  input  logic             i_resp_done,
  output logic [SEL_W-1:0] o_sel_0,
  output logic [SEL_W-1:0] o_sel_1,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [7:0]       o_err_cnt
);

  localparam int BIT_W = (CHAL_W > 1) ? $clog2(CHAL_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SEND, S_WAIT, S_GAP, S_NEXT, S_DONE
  } state_t;

`ifdef PUF_SCHED_GAP_EN
  localparam state_t WAIT_EXIT = S_GAP;
`else
  localparam state_t WAIT_EXIT = S_NEXT;
`endif

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] GAP_LAST = TMO_W'(GAP_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_HI   = SEL_W'(MUX_LENGTH - 1);
  localparam logic [SEL_W-1:0] SEL_HI2  = SEL_W'(MUX_LENGTH - 2);

  state_t              state, state_nx;
  logic [SEL_W-1:0]    sel0, sel1;
  logic [REP_W-1:0]    rep, rep_idx;
  logic                mode;
  logic [CHAL_W-1:0]   shreg;
  logic [BIT_W-1:0]    bit_idx;
  logic [TMO_W-1:0]    cnt;
  logic                timeout_flag;
  logic [7:0]          err_cnt;
  logic                last_rep, last_pair;

  assign last_rep  = (rep_idx == rep - 1'b1);
  assign last_pair = (sel0 == SEL_HI2) && (sel1 == SEL_HI);

  assign o_op_mode = mode;
  assign o_rx_data = shreg[CHAL_W-1];
  assign o_sel_0   = sel0;
  assign o_sel_1   = sel1;
  assign o_busy    = (state != S_IDLE);
  assign o_timeout = timeout_flag;
  assign o_err_cnt = err_cnt;

  // Next-state and state-decoded strobes; abort overrides every non-idle transition
  always_comb begin
    state_nx   = state;
    o_start    = 1'b0;
    o_rx_valid = 1'b0;
    o_done     = 1'b0;
    case (state)
      S_IDLE:  if (i_sweep_start && !i_sweep_abort) state_nx = S_START;
      S_START: begin
        o_start  = 1'b1;
        state_nx = S_SEND;
      end
      S_SEND: begin
        o_rx_valid = 1'b1;
        if (i_rx_ready && (bit_idx == '0)) state_nx = S_WAIT;
      end
      S_WAIT:  if (i_resp_done || (cnt == TMO_LAST)) state_nx = WAIT_EXIT;
      S_GAP:   if (cnt == GAP_LAST) state_nx = S_NEXT;
      S_NEXT:  state_nx = (last_rep && last_pair) ? S_DONE : S_START;
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if ((state != S_IDLE) && i_sweep_abort) state_nx = S_IDLE;
  end

  // State register, sweep bookkeeping, challenge shifter and wait/gap counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sel0         <= '0;
      sel1         <= SEL_W'(1);
      rep          <= '0;
      rep_idx      <= '0;
      mode         <= 1'b0;
      shreg        <= '0;
      bit_idx      <= '0;
      cnt          <= '0;
      timeout_flag <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state <= state_nx;
      // counter restarts on every entry into WAIT or GAP
      if ((state_nx == state) && ((state == S_WAIT) || (state == S_GAP)))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      case (state)
        S_IDLE: if (state_nx == S_START) begin
          mode         <= i_op_mode;
          rep          <= (i_rep_cnt == '0) ? REP_W'(1) : i_rep_cnt;
          sel0         <= '0;
          sel1         <= SEL_W'(1);
          rep_idx      <= '0;
          timeout_flag <= 1'b0;
          err_cnt      <= '0;
        end
        S_START: begin
          shreg   <= {sel0, sel1};
          bit_idx <= BIT_W'(CHAL_W - 1);
        end
        S_SEND: if (i_rx_ready) begin
          shreg   <= shreg << 1;
          bit_idx <= bit_idx - 1'b1;
        end
        S_WAIT: if ((state_nx == WAIT_EXIT) && !i_resp_done) begin
          timeout_flag <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        end
        S_NEXT: if (state_nx == S_START) begin
          if (last_rep) begin
            rep_idx <= '0;
            if (sel1 == SEL_HI) begin
              sel0 <= sel0 + 1'b1;
              sel1 <= sel0 + SEL_W'(2);
            end else begin
              sel1 <= sel1 + 1'b1;
            end
          end else begin
            rep_idx <= rep_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_chal_sweep_sched.sv
// tb/tb_puf_chal_sweep_sched.sv - scoreboard bench for puf_chal_sweep_sched (MUX_LENGTH=4, TIMEOUT_CYC=100)
module tb_puf_chal_sweep_sched;

  localparam int ML   = 4;
  localparam int CW   = 4;
  localparam int TMO  = 100;
  localparam int GAPC = 8;
`ifdef PUF_SCHED_GAP_EN
  localparam int GEXTRA = GAPC;
`else
  localparam int GEXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sweep_start = 1'b0;
  logic       sweep_abort = 1'b0;
  logic       op_mode = 1'b0;
  logic [3:0] rep_cnt = 4'd1;
  logic       o_start, o_op_mode, rx_valid, rx_data, o_busy, o_done, o_timeout;
  logic       rx_ready = 1'b1;
  logic       resp_done = 1'b0;
  logic [1:0] sel_0, sel_1;
  logic [7:0] err_cnt;

  puf_chal_sweep_sched #(
    .MUX_LENGTH(ML), .REP_W(4), .TMO_W(16), .TIMEOUT_CYC(TMO), .GAP_CYC(GAPC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_sweep_start(sweep_start), .i_sweep_abort(sweep_abort),
    .i_op_mode(op_mode), .i_rep_cnt(rep_cnt), .o_start(o_start), .o_op_mode(o_op_mode),
    .i_rx_ready(rx_ready), .o_rx_valid(rx_valid), .o_rx_data(rx_data),
    .i_resp_done(resp_done), .o_sel_0(sel_0), .o_sel_1(sel_1), .o_busy(o_busy),
    .o_done(o_done), .o_timeout(o_timeout), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  int cyc = 0;
  int words_seen, done_cnt, start_cnt, bitcnt;
  logic [3:0] word;
  int resp_cd = 0;
  bit resp_en = 1'b1;
  int ready_mode = 0;
  int last_cyc, resp_cyc;
  bit have_last = 1'b0;
  bit prev_stall = 1'b0;
  logic prev_data;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // input driver: ready pattern and delayed response pulse, updated just after each edge
  always @(posedge clk) begin
    cyc++;
    #1;
    rx_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    resp_done = 1'b0;
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) resp_done = 1'b1;
    end
  end

  // output monitor: word assembly against the scoreboard, hold checks, start latency
  always @(negedge clk) if (rst_n) begin
    if (prev_stall) begin
      check("hold_valid", rx_valid, 1);
      check("hold_data", rx_data, prev_data);
    end
    prev_stall = rx_valid && !rx_ready;
    prev_data  = rx_data;
    if (o_start) begin
      start_cnt++;
      if (have_last) begin
        check("start_latency", cyc,
              resp_en ? resp_cyc + 2 + GEXTRA : last_cyc + TMO + 2 + GEXTRA);
        have_last = 1'b0;
      end
    end
    if (rx_valid && rx_ready) begin
      word = {word[2:0], rx_data};
      bitcnt++;
      if (bitcnt == CW) begin
        bitcnt = 0;
        words_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL word_extra: got %b expected none", word);
        end else begin
          check("word", word, exp_q.pop_front());
        end
        last_cyc  = cyc;
        have_last = 1'b1;
        if (resp_en) resp_cd = 10;
      end
    end
    if (resp_done && o_busy) resp_cyc = cyc;
    if (o_done) done_cnt++;
  end

  task automatic start_sweep(input logic [3:0] rep, input logic mode);
    int r;
    r = (rep == 0) ? 1 : int'(rep);
    exp_q.delete();
    for (int s0 = 0; s0 < ML; s0++)
      for (int s1 = s0 + 1; s1 < ML; s1++)
        for (int k = 0; k < r; k++) exp_q.push_back({s0[1:0], s1[1:0]});
    words_seen = 0; done_cnt = 0; start_cnt = 0; bitcnt = 0;
    have_last = 1'b0; prev_stall = 1'b0;
    op_mode = mode;
    rep_cnt = rep;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    check("start_op_mode", o_op_mode, mode);
    check("start_timeout_clr", o_timeout, 0);
    check("start_err_clr", err_cnt, 0);
    check("start_sel", {sel_0, sel_1}, 4'b0001);
  endtask

  task automatic finish_sweep(input int expw);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done_cnt > 0), 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("word_count", words_seen, expw);
    check("queue_empty", exp_q.size(), 0);
    check("idle_after", o_busy, 0);
  endtask

  typedef struct {
    logic [3:0] rep;
    int         rmode;
    bit         resp;
    int         words;
    int         err;
    int         tmo;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{4'd1, 0, 1'b1, 6,  0, 0};
    vecs[1] = '{4'd0, 0, 1'b1, 6,  0, 0};
    vecs[2] = '{4'd3, 0, 1'b1, 18, 0, 0};
    vecs[3] = '{4'd1, 1, 1'b1, 6,  0, 0};
    vecs[4] = '{4'd1, 0, 1'b0, 6,  6, 1};

    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_start, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_err", err_cnt, 0);
    check("rst_sel", {sel_0, sel_1}, 4'b0001);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      ready_mode = vecs[i].rmode;
      resp_en    = vecs[i].resp;
      start_sweep(vecs[i].rep, logic'(i % 2));
      finish_sweep(vecs[i].words);
      check("err_cnt", err_cnt, vecs[i].err);
      check("timeout", o_timeout, vecs[i].tmo);
    end

    // abort during SEND of the third challenge, after two timeouts
    ready_mode = 0;
    resp_en    = 1'b0;
    start_sweep(4'd1, 1'b0);
    n = 0;
    while (start_cnt < 3 && n < 1000) begin @(negedge clk); n++; end
    check("abort_reach3", start_cnt, 3);
    n = 0;
    while (!rx_valid && n < 10) begin @(negedge clk); n++; end
    sweep_abort = 1'b1;
    @(negedge clk);
    sweep_abort = 1'b0;
    check("abort_valid", rx_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_keep_tmo", o_timeout, 1);
    check("abort_keep_err", err_cnt, 2);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    resp_en = 1'b1;
    start_sweep(4'd1, 1'b1);
    finish_sweep(6);
    check("after_abort_err", err_cnt, 0);

    // reset mid-sweep returns everything to power-up values
    resp_en = 1'b0;
    start_sweep(4'd2, 1'b1);
    n = 0;
    while (err_cnt == 0 && n < 1000) begin @(negedge clk); n++; end
    check("midrst_err_seen", err_cnt, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", o_busy, 0);
    check("midrst_err", err_cnt, 0);
    check("midrst_tmo", o_timeout, 0);
    check("midrst_mode", o_op_mode, 0);
    check("midrst_sel", {sel_0, sel_1}, 4'b0001);
    check("midrst_valid", rx_valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
